// File: rtl/cpu_ram_bank.sv
// cpu_ram_bank -- responder side of the mini-CPU memory handshake.
//
// Holds DEPTH words of WIDTH bits and serves GET (read), SET (write) and
// RESET (clear-all) requests.  Handshake (four-phase, valid/ready style):
// the requester raises `operation` to a non-IDLE code and holds it until
// `done` rises; it then returns `operation` to IDLE, which drops `done` on
// the next edge.  Request fields are latched only when accepted in S_IDLE;
// anything seen on the inputs while busy is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (FSM and outputs only)
//   operation  0 = IDLE, 1 = GET, 2 = SET, 3 = RESET
//   address    word address, latched on acceptance
//   data_in    write data, latched on acceptance of a SET
//   data_out   last word read (registered); zero after a clear
//   done       request complete, held until operation returns to IDLE
//   busy       high whenever the FSM is not idle
//   dbg_state  current FSM state encoding, for observation only
//
// Optional feature: define RAM_INIT_CLEAR_EN to sweep the array to zero
// automatically after reset deasserts.  The sweep runs with done = 0 and
// busy = 1, ignores requests and returns straight to S_IDLE.  Without it,
// array contents survive reset and are undefined after power-up.
module cpu_ram_bank #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       operation,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_GET   = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             init_q, init_d;   // current sweep is the post-reset one

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        clr_cnt_d  = clr_cnt_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        init_d     = init_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = data_q;

        case (state_q)
            S_IDLE: begin
                case (operation)
                    OP_GET: begin
                        addr_d  = address;
                        state_d = S_READ;
                    end
                    OP_SET: begin
                        addr_d  = address;
                        data_d  = data_in;
                        state_d = S_WRITE;
                    end
                    OP_RESET: begin
                        clr_cnt_d = '0;
                        state_d   = S_CLEAR;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_READ: begin
                data_out_d = mem[addr_q];
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d  = '0;
                    data_out_d = '0;
                    if (init_q) begin
                        // Power-up sweep: no handshake to complete.
                        init_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A different non-IDLE code here is not a new request.
                if (operation == OP_IDLE) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_INIT_CLEAR_EN
            state_q <= S_CLEAR;
            init_q  <= 1'b1;
`else
            state_q <= S_IDLE;
            init_q  <= 1'b0;
`endif
            addr_q     <= '0;
            data_q     <= '0;
            clr_cnt_q  <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clr_cnt_q  <= clr_cnt_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Reset wins over a pending write: an uncommitted SET or the remainder
    // of a clear sweep is dropped on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out  = data_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_ram_bank.sv
// Bench for cpu_ram_bank: directed scenarios plus randomized GET/SET/RESET
// traffic, checked against an array model of the word store.
module tb_cpu_ram_bank;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_GET   = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  operation = OP_IDLE;
    logic [3:0]  address = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    cpu_ram_bank dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] model_mem [16];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge. Issues one request, waits for done, checks
    // latency and result, then releases and checks done/busy drop.
    task automatic do_req(input logic [1:0] op, input logic [3:0] a,
                          input logic [15:0] d, input string tag);
        int lat;
        int exp_lat;
        bit seen;
        logic [15:0] exp_word;
        operation = op;
        address   = a;
        data_in   = d;
        exp_lat   = (op == OP_RESET) ? 17 : 2;
        case (op)
            OP_GET:   exp_q.push_back(model_mem[a]);
            OP_SET:   model_mem[a] = d;
            OP_RESET: for (int i = 0; i < 16; i++) model_mem[i] = '0;
            default: ;
        endcase
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, lat, exp_lat);
            if (op == OP_GET) begin
                exp_word = exp_q.pop_front();
                check({tag, " read_data"}, {16'd0, data_out}, {16'd0, exp_word});
            end else if (op == OP_RESET) begin
                check({tag, " data_out_cleared"}, {16'd0, data_out}, 32'd0);
            end
        end
        operation = OP_IDLE;
        address   = 4'($urandom);
        data_in   = 16'($urandom);
        @(negedge clk);
        check({tag, " done_release"}, {31'd0, done}, 32'd0);
        check({tag, " busy_release"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic fill_all_nonzero();
        for (int i = 0; i < 16; i++)
            do_req(OP_SET, 4'(i), 16'($urandom_range(1, 16'hFFFF)), "fill");
    endtask

    task automatic get_all(input string tag);
        for (int i = 0; i < 16; i++)
            do_req(OP_GET, 4'(i), 16'd0, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  rop;
        logic [15:0] rdat;
        logic [15:0] old_word;
        logic [15:0] held_word;

        repeat (3) @(negedge clk);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data_out", {16'd0, data_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Establish known contents.
        do_req(OP_RESET, 4'd0, 16'd0, "init_sweep");
        get_all("init_readback");

        // SET then GET.
        do_req(OP_SET, 4'd5, 16'h1234, "set5");
        do_req(OP_GET, 4'd5, 16'd0, "get5");

        // Held request: GET addr 3, keep operation at GET for 10 cycles.
        do_req(OP_SET, 4'd3, 16'hA5C3, "set3");
        operation = OP_GET;
        address   = 4'd3;
        held_word = model_mem[3];
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("held_first_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            address = 4'($urandom);
            data_in = 16'($urandom);
            @(negedge clk);
            check("held_done", {31'd0, done}, 32'd1);
            check("held_data_out", {16'd0, data_out}, {16'd0, held_word});
        end
        operation = OP_IDLE;
        @(negedge clk);
        check("held_release", {31'd0, done}, 32'd0);

        // Request switch without release: SET in S_DONE must be ignored.
        do_req(OP_SET, 4'd4, 16'h0F0F, "set4");
        operation = OP_GET;
        address   = 4'd4;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("switch_get_done", {31'd0, done}, 32'd1);
        operation = OP_SET;
        data_in   = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("switch_done_held", {31'd0, done}, 32'd1);
            check("switch_busy_held", {31'd0, busy}, 32'd1);
        end
        operation = OP_IDLE;
        @(negedge clk);
        check("switch_release", {31'd0, done}, 32'd0);
        do_req(OP_GET, 4'd4, 16'd0, "switch_readback");

        // 7-bit immediate arrives zero-extended and is stored as given.
        do_req(OP_SET, 4'd9, {9'd0, 7'h7F}, "set_imm7");
        do_req(OP_GET, 4'd9, 16'd0, "get_imm7");

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:             rop = OP_RESET;
                1, 2, 3, 4:    rop = OP_SET;
                default:       rop = OP_GET;
            endcase
            rdat = ($urandom_range(0, 3) == 0) ? {9'd0, 7'($urandom)} : 16'($urandom);
            do_req(rop, 4'($urandom), rdat, "random");
        end

        // Full RESET sweep over nonzero contents.
        fill_all_nonzero();
        do_req(OP_RESET, 4'd0, 16'd0, "sweep");
        get_all("sweep_readback");

        // Reset mid-write: SET accepted, rst on the next edge.
        fill_all_nonzero();
        do_req(OP_GET, 4'd7, 16'd0, "pre_midwrite_get");
        old_word  = model_mem[2];
        operation = OP_SET;
        address   = 4'd2;
        data_in   = 16'hBEEF;
        @(negedge clk);
        rst       = 1'b1;
        operation = OP_IDLE;
        @(negedge clk);
        check("midwrite_done", {31'd0, done}, 32'd0);
        check("midwrite_busy", {31'd0, busy}, 32'd0);
        check("midwrite_data_out", {16'd0, data_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        model_mem[2] = old_word;
        do_req(OP_GET, 4'd2, 16'd0, "midwrite_readback");

        // Reset mid-sweep: rst sampled 8 edges after acceptance.
        fill_all_nonzero();
        operation = OP_RESET;
        repeat (8) @(negedge clk);
        rst       = 1'b1;
        operation = OP_IDLE;
        @(negedge clk);
        check("midsweep_done", {31'd0, done}, 32'd0);
        check("midsweep_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) model_mem[i] = '0;
        @(negedge clk);
        get_all("midsweep_readback");

        // Request still asserted as rst deasserts is accepted next edge.
        rst       = 1'b1;
        operation = OP_SET;
        address   = 4'd11;
        data_in   = 16'h4321;
        @(negedge clk);
        rst = 1'b0;
        model_mem[11] = 16'h4321;
        begin
            int  lat;
            bit  seen;
            lat  = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                lat++;
                if (done) seen = 1'b1;
            end
            check("post_rst_accept_latency", seen ? lat : 0, 32'd2);
        end
        operation = OP_IDLE;
        @(negedge clk);
        do_req(OP_GET, 4'd11, 16'd0, "post_rst_readback");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_ram_bank.md
# cpu_ram_bank

Responder side of the mini-CPU memory handshake. Holds sixteen 16-bit words and serves GET (read), SET (write) and RESET (clear-all) requests from the CPU controller. Each request uses a four-phase handshake: `operation` is held non-IDLE until `done` rises, then returned to IDLE, which drops `done`. The block sits between the CPU sequencer and the display/attribute path that observes `data_out`.

## Interface
- `DEPTH`, 16: number of words; the address is `$clog2(DEPTH)` = 4 bits.
- `WIDTH`, 16: word width in bits.
- `clk`  in  1: single clock; all logic is clocked on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `operation`  in  2: request code. 0 = IDLE, 1 = GET, 2 = SET, 3 = RESET.
- `address`  in  4: word address; sampled only when a request is accepted.
- `data_in`  in  16: write data; sampled only when a SET is accepted.
- `data_out`  out  16: last read word, registered.
- `done`  out  1: request complete; held high until `operation` returns to IDLE.
- `busy`  out  1: high whenever the FSM is not in S_IDLE.

## Operation
- States: S_IDLE, S_READ, S_WRITE, S_CLEAR, S_DONE.
- **S_IDLE**
  - `operation` = GET: latch `address` into `addr_q` and go to S_READ.
  - `operation` = SET: latch `address` and `data_in` and go to S_WRITE.
  - `operation` = RESET: set `clr_cnt` = 0 and go to S_CLEAR.
  - `operation` = IDLE: stay in S_IDLE.
- **S_READ:** `data_out <= mem[addr_q]`, `done <= 1`, go to S_DONE.
- **S_WRITE:** `mem[addr_q] <= data_q`, `done <= 1`, go to S_DONE. `data_out` is unchanged.
- **S_CLEAR:** `mem[clr_cnt] <= 0`, `clr_cnt++`. When `clr_cnt` = DEPTH-1: `data_out <= 0`, `done <= 1`, go to S_DONE.
- **S_DONE:** hold `done` = 1 while `operation` != IDLE. On the first edge with `operation` = IDLE: `done <= 0` and go to S_IDLE.
- Changes on `operation`, `address` or `data_in` are ignored outside S_IDLE. Requests are latched at acceptance.
- A new non-IDLE code seen in S_DONE without an intervening IDLE is not a new request.
- Writes are full width. A narrower value from the CPU (for example a 7-bit immediate) arrives already zero-extended and is stored as given.
- Address wrap: `clr_cnt` is 4 bits; the sweep ends at 15, so there is no wrap. `address` always covers all 16 words.

## Timing
- Reset values: `done` = 0, `busy` = 0, `data_out` = 0, state S_IDLE, `clr_cnt` = 0. Array contents are governed by Configuration.
- GET latency: request sampled at edge E. `data_out` is valid and `done` = 1 after edge E+1.
- SET latency: request sampled at edge E. The memory holds the new word and `done` = 1 after edge E+1.
- RESET latency: request sampled at edge E. `done` = 1 after edge E+16. Words 0..15 are zeroed at edges E+1..E+16.
- Release: `operation` = IDLE sampled at edge F in S_DONE gives `done` = 0 after F. A new request is accepted no earlier than edge F+1.
- Minimum back-to-back GET period is 3 clocks: request, done, release.
- `busy` falls on the same edge that `done` falls.
- `rst` while the FSM is busy:
  - `rst` has priority over any request on the same edge.
  - An uncommitted write in S_WRITE is discarded.
  - A partial clear sweep leaves words below `clr_cnt` zeroed and the rest untouched.
  - If `operation` is still non-IDLE after `rst` deasserts, a new request is accepted on the next edge.

## Configuration
- `RAM_INIT_CLEAR_EN` defined:
  - Deassertion of `rst` enters S_CLEAR with `clr_cnt` = 0. The 16 words are zeroed automatically with `done` held at 0 and `busy` = 1.
  - Requests are ignored during the sweep. The FSM returns directly to S_IDLE, not through S_DONE.
- `RAM_INIT_CLEAR_EN` not defined:
  - `rst` affects only the FSM and the outputs. Array contents survive reset and are undefined after power-up until written or cleared.

## Test plan
- **SET then GET:** SET addr 5 with 0x1234, release, then GET addr 5 -> `done` one edge after each request, `data_out` = 0x1234, and `done` = 0 one edge after IDLE.
- **Held request:** GET addr 3 with `operation` left at GET for 10 cycles -> `done` stays 1 for all 10 cycles. No second read; a `data_in` or `address` change has no effect.
- **RESET sweep:** fill all 16 words with nonzero values, then RESET -> `done` rises exactly 16 edges after acceptance, `data_out` = 0, and a GET of every address returns 0.
- **Reset mid-write:** accept SET addr 2 with 0xBEEF and assert `rst` on the next edge -> addr 2 keeps its old value, and `done`, `busy` and `data_out` are all 0.
- **Reset mid-sweep:** assert `rst` 8 edges into a RESET sweep -> words 0..6 are 0 and words 7..15 are unchanged. With `RAM_INIT_CLEAR_EN` defined, `busy` stays high for 16 edges after `rst` falls and all words read 0.
- **Request switch without release:** GET then SET issued without an IDLE in between -> the SET is ignored until IDLE is sampled, and the memory is unchanged.
